// File: rtl/cpu_run_ctrl.sv
// Run controller for the TopLevel CPU: clears data memory and regfile, loads operands,
// releases the CPU, waits for halt or timeout, then reads back and checks result words.
module cpu_run_ctrl #(
  parameter int DW        = 8,
  parameter int AW        = 8,
  parameter int NREG      = 16,
  parameter int N_LOAD    = 4,
  parameter int LOAD_BASE = 1,
  parameter int N_RES     = 4,
  parameter int RES_BASE  = 5,
  parameter int TIMEOUT   = 4096,
  parameter int CW        = 16,
  localparam int RW       = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic                CLK,
  input  logic                start,
  input  logic                run,
  input  logic [N_LOAD*DW-1:0] load_img,
  input  logic [N_RES*DW-1:0] expect_img,
  output logic                dut_start,
  input  logic                dut_halt,
  output logic                mem_own,
  output logic [AW-1:0]       mem_addr,
  output logic [DW-1:0]       mem_wdata,
  output logic                mem_we,
  input  logic [DW-1:0]       mem_rdata,
  output logic [RW-1:0]       rf_addr,
  output logic                rf_we,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic                timeout,
  output logic [CW-1:0]       cycles,
  output logic [N_RES*DW-1:0] result_img,
  output logic [2:0]          dbg_state
);

  localparam int DEPTH = 1 << AW;
  localparam int IW    = $clog2(DEPTH + NREG + N_LOAD + N_RES + 2);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLR_MEM = 3'd1,
    S_CLR_RF  = 3'd2,
    S_LOAD    = 3'd3,
    S_RUN     = 3'd4,
    S_READ    = 3'd5,
    S_DONE    = 3'd6
  } state_e;

  state_e                state_q, state_d;
  logic [IW-1:0]         cnt_q, cnt_d;
  logic                  dut_start_q, dut_start_d;
  logic                  mem_own_q, mem_own_d;
  logic [AW-1:0]         mem_addr_q, mem_addr_d;
  logic [DW-1:0]         mem_wdata_q, mem_wdata_d;
  logic                  mem_we_q, mem_we_d;
  logic [RW-1:0]         rf_addr_q, rf_addr_d;
  logic                  rf_we_q, rf_we_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic                  timeout_q, timeout_d;
  logic [CW-1:0]         cycles_q, cycles_d;
  logic [N_RES*DW-1:0]   result_q, result_d;
  logic                  match_q, match_d;

  // Every output is registered: the values computed here are what the
  // outputs will show during the cycle spent in state_d.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dut_start_d = 1'b1;
    mem_own_d   = 1'b1;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    mem_we_d    = 1'b0;
    rf_addr_d   = '0;
    rf_we_d     = 1'b0;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    timeout_d   = timeout_q;
    cycles_d    = cycles_q;
    result_d    = result_q;
    match_d     = match_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (run) begin
          state_d   = S_CLR_MEM;
          cnt_d     = '0;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          timeout_d = 1'b0;
          cycles_d  = '0;
          result_d  = '0;
          match_d   = 1'b1;
          mem_we_d  = 1'b1;
        end
      end

      S_CLR_MEM: begin
        if (cnt_q == IW'(DEPTH - 1)) begin
          state_d = S_CLR_RF;
          cnt_d   = '0;
          rf_we_d = 1'b1;
        end else begin
          cnt_d      = cnt_q + IW'(1);
          mem_we_d   = 1'b1;
          mem_addr_d = AW'(int'(cnt_q) + 1);
        end
      end

      S_CLR_RF: begin
        if (cnt_q == IW'(NREG - 1)) begin
          state_d     = S_LOAD;
          cnt_d       = '0;
          mem_we_d    = 1'b1;
          mem_addr_d  = AW'(LOAD_BASE);
          mem_wdata_d = load_img[0 +: DW];
        end else begin
          cnt_d     = cnt_q + IW'(1);
          rf_we_d   = 1'b1;
          rf_addr_d = RW'(int'(cnt_q) + 1);
        end
      end

      S_LOAD: begin
        if (cnt_q == IW'(N_LOAD - 1)) begin
          state_d     = S_RUN;
          cnt_d       = '0;
          dut_start_d = 1'b0;
          mem_own_d   = 1'b0;
        end else begin
          cnt_d      = cnt_q + IW'(1);
          mem_we_d   = 1'b1;
          // Address arithmetic wraps modulo the memory depth.
          mem_addr_d = AW'(LOAD_BASE + int'(cnt_q) + 1);
          for (int i = 0; i < N_LOAD; i++) begin
            if (int'(cnt_q) + 1 == i) mem_wdata_d = load_img[i*DW +: DW];
          end
        end
      end

      S_RUN: begin
        // Halt takes priority over a timeout landing in the same cycle.
        if (dut_halt) begin
          state_d    = S_READ;
          cnt_d      = '0;
          mem_addr_d = AW'(RES_BASE);
        end else if (cycles_q == CW'(TIMEOUT - 1)) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
          pass_d    = 1'b0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
        end else begin
          cycles_d    = cycles_q + CW'(1);
          dut_start_d = 1'b0;
          mem_own_d   = 1'b0;
        end
      end

      S_READ: begin
        // Read data for the address issued in cycle j arrives in cycle j+1.
        for (int j = 0; j < N_RES; j++) begin
          if (int'(cnt_q) == j + 1) begin
            result_d[j*DW +: DW] = mem_rdata;
            if (mem_rdata != expect_img[j*DW +: DW]) match_d = 1'b0;
          end
        end
        if (int'(cnt_q) == N_RES) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = match_d;
        end else begin
          cnt_d = cnt_q + IW'(1);
          if (int'(cnt_q) + 1 < N_RES) mem_addr_d = AW'(RES_BASE + int'(cnt_q) + 1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (start) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      dut_start_q <= 1'b1;
      mem_own_q   <= 1'b1;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      rf_addr_q   <= '0;
      rf_we_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
      cycles_q    <= '0;
      result_q    <= '0;
      match_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dut_start_q <= dut_start_d;
      mem_own_q   <= mem_own_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      rf_addr_q   <= rf_addr_d;
      rf_we_q     <= rf_we_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      timeout_q   <= timeout_d;
      cycles_q    <= cycles_d;
      result_q    <= result_d;
      match_q     <= match_d;
    end
  end

  assign dut_start  = dut_start_q;
  assign mem_own    = mem_own_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_we     = mem_we_q;
  assign rf_addr    = rf_addr_q;
  assign rf_we      = rf_we_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign timeout    = timeout_q;
  assign cycles     = cycles_q;
  assign result_img = result_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: memory/regfile/CPU models, directed and random sequences,
// results compared against an image-level reference model.
module tb_cpu_run_ctrl;

  localparam int DW        = 8;
  localparam int AW        = 8;
  localparam int NREG      = 16;
  localparam int N_LOAD    = 4;
  localparam int LOAD_BASE = 1;
  localparam int N_RES     = 4;
  localparam int RES_BASE  = 5;
  localparam int TIMEOUT   = 100;
  localparam int CW        = 16;
  localparam int RW        = $clog2(NREG);
  localparam int DEPTH     = 1 << AW;
  localparam int LW        = N_LOAD * DW;
  localparam int XW        = N_RES * DW;
  localparam int SETUP     = 1 + DEPTH + NREG + N_LOAD;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic           start, run;
  logic [LW-1:0]  load_img;
  logic [XW-1:0]  expect_img;
  logic           dut_start, dut_halt, mem_own, mem_we, rf_we;
  logic           busy, done, pass, timeout;
  logic [AW-1:0]  mem_addr;
  logic [DW-1:0]  mem_wdata, mem_rdata;
  logic [RW-1:0]  rf_addr;
  logic [CW-1:0]  cycles;
  logic [XW-1:0]  result_img;
  logic [2:0]     dbg_state;

  cpu_run_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .CLK(clk), .start(start), .run(run), .load_img(load_img), .expect_img(expect_img),
    .dut_start(dut_start), .dut_halt(dut_halt), .mem_own(mem_own), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata), .rf_addr(rf_addr),
    .rf_we(rf_we), .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .cycles(cycles), .result_img(result_img), .dbg_state(dbg_state)
  );

  // ---------------- memory, regfile and CPU models ----------------
  logic [DW-1:0]    mem [DEPTH];
  logic [DW-1:0]    rf  [NREG];
  logic [DW-1:0]    rd_q;
  logic             prefill_req;
  int               cpu_cnt = 0;
  int               halt_at;
  logic [N_RES-1:0] cpu_mask;
  logic [XW-1:0]    cpu_val;

  assign mem_rdata = rd_q;
  assign dut_halt  = !dut_start && (cpu_cnt == halt_at);

  always @(posedge clk) cpu_cnt <= dut_start ? 0 : cpu_cnt + 1;

  always @(posedge clk) begin
    if (prefill_req) begin
      for (int a = 0; a < DEPTH; a++) mem[a] <= DW'($urandom);
      for (int r = 0; r < NREG; r++) rf[r] <= DW'($urandom | 1);
    end else begin
      if (mem_own) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
      end else if (cpu_cnt == 0) begin
        for (int j = 0; j < N_RES; j++)
          if (cpu_mask[j]) mem[AW'(RES_BASE + j)] <= cpu_val[j*DW +: DW];
      end
      if (rf_we) rf[rf_addr] <= '0;
    end
    rd_q <= mem[mem_addr];
  end

  // ---------------- write-port monitor ----------------
  logic mon_clr;
  int   n_memw, n_rfw, n_both, n_bad_wr, n_order, first_run;
  bit   run_seen;

  always @(negedge clk) begin
    if (mon_clr) begin
      n_memw = 0; n_rfw = 0; n_both = 0; n_bad_wr = 0; n_order = 0;
      first_run = -1; run_seen = 1'b0;
    end else begin
      if (mem_we && rf_we) n_both++;
      if (!dut_start && !run_seen) begin
        run_seen  = 1'b1;
        first_run = cyc;
      end
      if ((mem_we || rf_we) && (run_seen || !dut_start)) n_bad_wr++;
      if (mem_we) begin
        if (n_memw < DEPTH) begin
          if (mem_addr !== AW'(n_memw) || mem_wdata !== '0) n_order++;
        end else if (n_memw - DEPTH < N_LOAD) begin
          if (mem_addr !== AW'(LOAD_BASE + n_memw - DEPTH) ||
              mem_wdata !== load_img[(n_memw - DEPTH)*DW +: DW]) n_order++;
        end else begin
          n_order++;
        end
        n_memw++;
      end
      if (rf_we) begin
        if (rf_addr !== RW'(n_rfw)) n_order++;
        n_rfw++;
      end
    end
  end

  // ---------------- scoreboard ----------------
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [63:0] exp_q[$];
  logic [DW-1:0] ref_mem [DEPTH];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Final memory image: cleared, operands loaded, then CPU result writes.
  task automatic build_ref(input logic [LW-1:0] ld, input logic [N_RES-1:0] msk,
                           input logic [XW-1:0] vals);
    for (int a = 0; a < DEPTH; a++) ref_mem[a] = '0;
    for (int i = 0; i < N_LOAD; i++) ref_mem[(LOAD_BASE + i) % DEPTH] = ld[i*DW +: DW];
    for (int j = 0; j < N_RES; j++)
      if (msk[j]) ref_mem[(RES_BASE + j) % DEPTH] = vals[j*DW +: DW];
  endtask

  function automatic logic [XW-1:0] ref_result();
    logic [XW-1:0] r;
    for (int j = 0; j < N_RES; j++) r[j*DW +: DW] = ref_mem[(RES_BASE + j) % DEPTH];
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [LW-1:0] ld, input logic [XW-1:0] ex, output int run_c);
    prefill_req = 1'b1;
    tick();
    prefill_req = 1'b0;
    load_img    = ld;
    expect_img  = ex;
    run         = 1'b1;
    mon_clr     = 1'b1;
    run_c       = cyc;
    tick();
    run         = 1'b0;
    mon_clr     = 1'b0;
  endtask

  task automatic run_seq(input string tag, input logic [LW-1:0] ld, input logic [XW-1:0] vals,
                         input logic [N_RES-1:0] msk, input int h, input logic [XW-1:0] ex,
                         input bit pulses);
    int   run_c, done_c;
    int   bad_img, bad_rf;
    bit   to;
    logic [XW-1:0] res;

    halt_at  = h;
    cpu_mask = msk;
    cpu_val  = vals;
    build_ref(ld, msk, vals);
    to  = (h > TIMEOUT - 1);
    res = to ? '0 : ref_result();
    exp_q.push_back({61'd0, 1'b1, !to && (res == ex), to});
    exp_q.push_back(64'(to ? TIMEOUT - 1 : h));
    exp_q.push_back(64'(res));
    exp_q.push_back(64'(to ? TIMEOUT : h + N_RES + 2));

    launch(ld, ex, run_c);
    check({tag, ".go_busy"},    64'(busy), 64'd1);
    check({tag, ".go_cleared"}, 64'({done, pass, timeout}), 64'd0);
    check({tag, ".go_cycles"},  64'(cycles), 64'd0);
    check({tag, ".go_result"},  64'(result_img), 64'd0);
    check({tag, ".go_clr0"},    64'({mem_we, mem_addr}), 64'({1'b1, AW'(0)}));

    for (int k = 0; k < 1000; k++) begin
      if (done) break;
      run = pulses && ((cyc == run_c + 20) || (cyc == run_c + SETUP));
      tick();
    end
    run    = 1'b0;
    done_c = cyc;
    check({tag, ".done_seen"}, 64'(done), 64'd1);

    check({tag, ".flags"},   64'({done, pass, timeout}), exp_q.pop_front());
    check({tag, ".cycles"},  64'(cycles), exp_q.pop_front());
    check({tag, ".result"},  64'(result_img), exp_q.pop_front());
    check({tag, ".latency"}, 64'(done_c - first_run), exp_q.pop_front());
    check({tag, ".setup"},   64'(first_run - run_c), 64'(SETUP));
    check({tag, ".n_memw"},  64'(n_memw), 64'(DEPTH + N_LOAD));
    check({tag, ".n_rfw"},   64'(n_rfw), 64'(NREG));
    check({tag, ".we_both"}, 64'(n_both), 64'd0);
    check({tag, ".late_wr"}, 64'(n_bad_wr), 64'd0);
    check({tag, ".wr_order"}, 64'(n_order), 64'd0);
    check({tag, ".idle_out"}, 64'({dut_start, mem_own, busy}), 64'({1'b1, 1'b1, 1'b0}));

    bad_img = 0;
    for (int a = 0; a < DEPTH; a++) if (mem[a] !== ref_mem[a]) bad_img++;
    bad_rf = 0;
    for (int r = 0; r < NREG; r++) if (rf[r] !== '0) bad_rf++;
    check({tag, ".mem_image"}, 64'(bad_img), 64'd0);
    check({tag, ".rf_clear"},  64'(bad_rf), 64'd0);

    repeat (3) tick();
    check({tag, ".hold"}, 64'({done, busy, result_img}), 64'({1'b1, 1'b0, res}));
  endtask

  task automatic reset_mid(input logic [LW-1:0] ld);
    int run_c;
    halt_at  = 1000;
    cpu_mask = '0;
    launch(ld, '0, run_c);
    while (cyc < run_c + 1 + DEPTH + NREG + 2) tick();
    check("rst.in_load2", 64'({mem_we, mem_addr, mem_wdata}),
          64'({1'b1, AW'(LOAD_BASE + 2), ld[2*DW +: DW]}));
    start = 1'b1;
    tick();
    check("rst.abort", 64'({mem_we, rf_we, busy, dut_start, mem_own, done}), 64'b000110);
    start = 1'b0;
    repeat (3) tick();
    check("rst.quiet", 64'({mem_we, rf_we, busy, dut_start}), 64'b0001);
  endtask

  // ---------------- stimulus ----------------
  localparam logic [LW-1:0] T1_LD   = {8'hfb, 8'hff, 8'hff, 8'h03};
  localparam logic [XW-1:0] T1_RES  = {8'hfa, 8'hfe, 8'hff, 8'h03};
  localparam logic [XW-1:0] T2_EX   = {8'hfa, 8'hff, 8'hff, 8'h03};
  localparam logic [XW-1:0] PART_EX = {8'h00, 8'hfe, 8'h00, 8'h03};

  initial begin
    logic [LW-1:0]    r_ld;
    logic [XW-1:0]    r_val, r_ex;
    logic [N_RES-1:0] r_msk;
    int               r_h;

    start = 1'b1; run = 1'b0; load_img = '0; expect_img = '0;
    halt_at = -1; cpu_mask = '0; cpu_val = '0; prefill_req = 1'b0; mon_clr = 1'b0;
    repeat (3) tick();
    check("rst.dut_start",  64'(dut_start), 64'd1);
    check("rst.mem_own",    64'(mem_own), 64'd1);
    check("rst.mem_we",     64'(mem_we), 64'd0);
    check("rst.rf_we",      64'(rf_we), 64'd0);
    check("rst.busy",       64'(busy), 64'd0);
    check("rst.done",       64'(done), 64'd0);
    check("rst.pass",       64'(pass), 64'd0);
    check("rst.timeout",    64'(timeout), 64'd0);
    check("rst.cycles",     64'(cycles), 64'd0);
    check("rst.result_img", 64'(result_img), 64'd0);
    check("rst.mem_addr",   64'(mem_addr), 64'd0);
    start = 1'b0;
    tick();
    check("idle.after_rst", 64'({busy, dut_start}), 64'b01);

    run_seq("t1",         T1_LD, T1_RES, 4'hf, 37, T1_RES, 1'b0);
    run_seq("t2",         T1_LD, T1_RES, 4'hf, 37, T2_EX,  1'b0);
    run_seq("t3_timeout", T1_LD, T1_RES, 4'hf, 100000, T1_RES, 1'b0);
    reset_mid(T1_LD);
    run_seq("t4_rerun",   T1_LD, T1_RES, 4'hf, 37, T1_RES, 1'b0);
    run_seq("t5_pulses",  T1_LD, T1_RES, 4'hf, 0,  T1_RES, 1'b1);
    run_seq("t5_restart", T1_LD, T1_RES, 4'hf, 12, T2_EX,  1'b0);
    run_seq("halt_last",  T1_LD, T1_RES, 4'hf, TIMEOUT - 1, T1_RES, 1'b0);
    run_seq("halt_late",  T1_LD, T1_RES, 4'hf, TIMEOUT, T1_RES, 1'b0);
    run_seq("partial",    T1_LD, T1_RES, 4'b0101, 5, PART_EX, 1'b0);

    for (int n = 0; n < 8; n++) begin
      r_ld  = LW'({$urandom, $urandom});
      r_val = XW'({$urandom, $urandom});
      r_msk = N_RES'($urandom);
      r_h   = $urandom_range(0, 130);
      build_ref(r_ld, r_msk, r_val);
      r_ex  = ref_result();
      if ($urandom_range(0, 1) == 1) r_ex[$urandom_range(0, XW - 1)] ^= 1'b1;
      run_seq($sformatf("rand%0d", n), r_ld, r_val, r_msk, r_h, r_ex, n[0]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
